// File: rtl/mem_write_pkg.sv
// rtl/mem_write_pkg.sv - shared types and command constants for the memory write scheduler
// Contents:
//   state_t       scheduler FSM states
//   IDLE_ADDR     address driven on the memory port whenever no write is in progress
//   BTN_ADDR      address targeted by every button command
//   BTN_DATA      per-button write data (btn[0], btn[1], btn[2])
//   SRC_BTN/SYS   encoding of the write source reported on last_src
//   btn_cmd_data  write data for a one-hot selected button
package mem_write_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_GAP
    } state_t;

    localparam int   IDLE_ADDR    = 15;
    localparam int   BTN_ADDR     = 1;
    localparam int   BTN_DATA [3] = '{1, 2, 0};
    localparam logic SRC_BTN      = 1'b0;
    localparam logic SRC_SYS      = 1'b1;

    function automatic int btn_cmd_data(input logic [2:0] sel);
        if (sel[0]) return BTN_DATA[0];
        if (sel[1]) return BTN_DATA[1];
        return BTN_DATA[2];
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchronizer and debouncer for one active-low button
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous reset, active-high
//   btn_n  in   raw button, active-low, asynchronous to clk
//   press  out  one-cycle pulse when the debounced level goes from released to pressed
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;
    logic             flip;

    // cnt counts consecutive samples that disagree with the debounced level;
    // the level follows once DEBOUNCE_CYC such samples have been seen in a row.
    assign flip  = (sync2 != level) && (cnt == CNT_W'(DEBOUNCE_CYC - 1));
    assign press = flip && !sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (flip) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_write_sched.sv
// rtl/mem_write_sched.sv - arbitrates button commands and system writes onto one memory write port
// Ports:
//   clk, rst             system clock, asynchronous active-high reset
//   btn[2:0]             raw active-low buttons
//   sys_req/addr/data    system write request, held until sys_gnt
//   sys_gnt              one-cycle grant, coincident with the system write strobe
//   mem_we/addr/wdata    memory write port, one strobe per accepted command
//   busy                 high while a write or its trailing bubble is in progress
//   last_src             source of the most recent write (0 button, 1 system)
module mem_write_sched
    import mem_write_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        btn,
    input  logic              sys_req,
    input  logic [ADDR_W-1:0] sys_addr,
    input  logic [DATA_W-1:0] sys_data,
    output logic              sys_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              last_src
);

    state_t            state;
    state_t            state_nx;
    logic [2:0]        press;
    logic [2:0]        pend;
    logic [2:0]        pend_sel;
    logic [2:0]        pend_clr;
    logic              btn_any;
    logic              load;
    logic              pick_sys;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    for (genvar i = 0; i < 3; i++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .btn_n(btn[i]),
            .press(press[i])
        );
    end

    // Lowest-index pending button wins among buttons.
    assign btn_any  = |pend;
    assign pend_sel = pend & (~pend + 3'd1);

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        pick_sys = 1'b0;
        pend_clr = '0;
        unique case (state)
            S_IDLE: begin
                if (btn_any || sys_req) begin
                    load     = 1'b1;
                    state_nx = S_WRITE;
                    // Contested: serve whichever source did not write last.
                    pick_sys = sys_req && (!btn_any || (last_src == SRC_BTN));
                    if (!pick_sys) begin
                        pend_clr = pend_sel;
                    end
                end
            end
            S_WRITE: state_nx = S_GAP;
            S_GAP:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            pend     <= '0;
            addr_q   <= ADDR_W'(IDLE_ADDR);
            wdata_q  <= '0;
            last_src <= SRC_SYS;
        end else begin
            state <= state_nx;
            // A press on an already pending button is dropped; a served bit clears.
            pend  <= (pend & ~pend_clr) | (press & ~pend);
            if (load) begin
                last_src <= pick_sys;
                addr_q   <= pick_sys ? sys_addr : ADDR_W'(BTN_ADDR);
                wdata_q  <= pick_sys ? sys_data : DATA_W'(btn_cmd_data(pend_sel));
            end
        end
    end

    // last_src is loaded with the chosen source as WRITE is entered, so during
    // WRITE it also identifies the current write.
    assign mem_we    = (state == S_WRITE);
    assign sys_gnt   = mem_we && (last_src == SRC_SYS);
    assign mem_addr  = mem_we ? addr_q : ADDR_W'(IDLE_ADDR);
    assign mem_wdata = wdata_q;
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_mem_write_sched.sv
// tb/tb_mem_write_sched.sv - scoreboard bench for mem_write_sched
module tb_mem_write_sched;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int DEB = 4;
    // A press held this many cycles is certainly debounced and pending.
    localparam int READY_CYC = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    btn;
    logic          sys_req;
    logic [AW-1:0] sys_addr;
    logic [DW-1:0] sys_data;
    logic          sys_gnt;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          busy;
    logic          last_src;

    mem_write_sched #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .DEBOUNCE_CYC(DEB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .sys_req  (sys_req),
        .sys_addr (sys_addr),
        .sys_data (sys_data),
        .sys_gnt  (sys_gnt),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .busy     (busy),
        .last_src (last_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            t;
    } wr_t;

    wr_t btn_q[$];
    wr_t sys_q[$];
    int  wr_cyc[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event seen, required none (cycle %0d)", name, cyc);
    endtask

    // Button command table from the block's definition.
    function automatic wr_t btn_cmd(input int i, input int t);
        wr_t e;
        e.addr = AW'(1);
        e.data = (i == 0) ? DW'(1) : (i == 1) ? DW'(2) : DW'(0);
        e.t    = t;
        return e;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic          prev_we    = 1'b0;
    logic          prev_src   = 1'b1;
    logic          sys_prev   = 1'b0;
    logic [DW-1:0] exp_wdata  = '0;
    int            last_we_cyc = -100;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_we     = 1'b0;
                prev_src    = 1'b1;
                sys_prev    = 1'b0;
                exp_wdata   = '0;
                last_we_cyc = -100;
                continue;
            end
            if (mem_we) begin
                wr_t e;
                logic btn_ready;
                btn_ready = (btn_q.size() > 0) && ((cyc - btn_q[0].t) >= READY_CYC);
                check("we_single_cycle", prev_we, 1'b0);
                check("we_spacing_ge3", (cyc - last_we_cyc) >= 3, 1'b1);
                check("busy_in_write", busy, 1'b1);
                check("last_src_tracks", last_src, sys_gnt);
                if (sys_prev && btn_ready) check("arb_alternate", sys_gnt, !prev_src);
                if (sys_gnt) begin
                    if (sys_q.size() == 0) flag("unexpected_sys_write");
                    else begin
                        e = sys_q.pop_front();
                        check("sys_addr", mem_addr, e.addr);
                        check("sys_data", mem_wdata, e.data);
                        exp_wdata = e.data;
                    end
                end else begin
                    if (btn_q.size() == 0) flag("unexpected_btn_write");
                    else begin
                        e = btn_q.pop_front();
                        check("btn_addr", mem_addr, e.addr);
                        check("btn_data", mem_wdata, e.data);
                        exp_wdata = e.data;
                    end
                end
                prev_src    = sys_gnt;
                last_we_cyc = cyc;
                wr_cyc.push_back(cyc);
            end else begin
                check("idle_addr", mem_addr, AW'(15));
                check("gnt_without_we", sys_gnt, 1'b0);
                check("wdata_hold", mem_wdata, exp_wdata);
                if (prev_we) check("busy_in_gap", busy, 1'b1);
            end
            prev_we  = mem_we;
            sys_prev = sys_req;
        end
    end

    // ---------------- stimulus ----------------
    task automatic btn_press(input logic [2:0] m);
        @(posedge clk); #1;
        btn = btn & ~m;
        for (int i = 0; i < 3; i++) if (m[i]) btn_q.push_back(btn_cmd(i, cyc));
        repeat (12) @(posedge clk);
        #1 btn = btn | m;
        repeat (10) @(posedge clk);
    endtask

    task automatic sys_send(input int n);
        bit got;
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            sys_addr = AW'($urandom);
            sys_data = DW'($urandom);
            sys_req  = 1'b1;
            sys_q.push_back('{sys_addr, sys_data, cyc});
            got = 1'b0;
            for (int w = 0; w < 60 && !got; w++) begin
                @(negedge clk);
                if (sys_gnt) got = 1'b1;
            end
            if (!got) begin
                flag("sys_gnt_timeout");
                sys_q.delete();
            end
            @(posedge clk); #1;
        end
        sys_req = 1'b0;
    endtask

    task automatic wait_we(output bit ok);
        ok = 1'b0;
        for (int w = 0; w < 40 && !ok; w++) begin
            @(negedge clk);
            if (mem_we) ok = 1'b1;
        end
        if (!ok) flag("mem_we_timeout");
    endtask

    task automatic drain();
        int w = 0;
        while ((btn_q.size() != 0 || sys_q.size() != 0) && w < 300) begin
            @(posedge clk);
            w++;
        end
        repeat (6) @(posedge clk);
        #1;
        check("queues_drained", (btn_q.size() == 0) && (sys_q.size() == 0), 1'b1);
        btn_q.delete();
        sys_q.delete();
    endtask

    initial begin
        bit       ok;
        logic [2:0] m;
        rst      = 1'b1;
        btn      = 3'b111;
        sys_req  = 1'b0;
        sys_addr = '0;
        sys_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, AW'(15));
        check("rst_mem_wdata", mem_wdata, DW'(0));
        check("rst_sys_gnt", sys_gnt, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_last_src", last_src, 1'b1);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        // Bouncing btn[0]: only the final steady low produces one write.
        wr_cyc.delete();
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            btn[0] = 1'b0;
            repeat (2) @(posedge clk);
            #1 btn[0] = 1'b1;
            repeat (2) @(posedge clk);
            #1;
        end
        btn[0] = 1'b0;
        btn_q.push_back(btn_cmd(0, cyc));
        repeat (14) @(posedge clk);
        #1 btn[0] = 1'b1;
        repeat (10) @(posedge clk);
        drain();
        check("bounce_write_count", wr_cyc.size(), 1);

        // All three buttons at once: data 1, 2, 0 exactly three cycles apart.
        wr_cyc.delete();
        btn_press(3'b111);
        drain();
        check("simul_write_count", wr_cyc.size(), 3);
        if (wr_cyc.size() == 3) begin
            check("simul_gap_1", wr_cyc[1] - wr_cyc[0], 3);
            check("simul_gap_2", wr_cyc[2] - wr_cyc[1], 3);
        end

        // Back-to-back system writes: one grant every third cycle.
        wr_cyc.delete();
        sys_send(5);
        drain();
        check("b2b_write_count", wr_cyc.size(), 5);
        for (int i = 1; i < wr_cyc.size(); i++) check("b2b_gap", wr_cyc[i] - wr_cyc[i-1], 3);

        // Contention: btn[1] against a continuous system stream; stream ends last.
        fork
            sys_send(6);
            begin
                repeat (2) @(posedge clk);
                btn_press(3'b010);
            end
        join
        drain();
        check("contention_last_src", last_src, 1'b1);

        // Request raised and withdrawn while busy: no system write.
        wr_cyc.delete();
        fork
            btn_press(3'b100);
            begin
                wait_we(ok);
                #1 sys_req = 1'b1;
                sys_addr = AW'(7);
                sys_data = DW'(8'hAB);
                @(posedge clk);
                #1 sys_req = 1'b0;
            end
        join
        drain();
        check("withdraw_write_count", wr_cyc.size(), 1);

        // Short re-press of btn[2] while it is still pending: one data-0 write.
        fork
            sys_send(5);
            begin
                repeat (2) @(posedge clk);
                #1 btn = 3'b000;
                for (int i = 0; i < 3; i++) btn_q.push_back(btn_cmd(i, cyc));
                repeat (8) @(posedge clk);
                #1 btn[2] = 1'b1;
                repeat (2) @(posedge clk);
                #1 btn[2] = 1'b0;
                repeat (10) @(posedge clk);
                #1 btn = 3'b111;
                repeat (10) @(posedge clk);
            end
        join
        drain();

        // Randomized mix of button batches, system bursts and contention.
        for (int it = 0; it < 12; it++) begin
            m = 3'($urandom_range(1, 7));
            case ($urandom_range(0, 2))
                0: btn_press(m);
                1: sys_send($urandom_range(1, 3));
                default: begin
                    fork
                        sys_send($countones(m) + 2);
                        begin
                            repeat ($urandom_range(0, 4)) @(posedge clk);
                            btn_press(m);
                        end
                    join
                end
            endcase
            drain();
        end

        // Reset in the middle of a write: strobe dies at once and never completes.
        wr_cyc.delete();
        @(posedge clk); #1;
        btn[0] = 1'b0;
        btn_q.push_back(btn_cmd(0, cyc));
        wait_we(ok);
        #2;
        rst = 1'b1;
        btn = 3'b111;
        #1;
        check("midrst_mem_we", mem_we, 1'b0);
        check("midrst_mem_addr", mem_addr, AW'(15));
        check("midrst_last_src", last_src, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_sys_gnt", sys_gnt, 1'b0);
        check("midrst_wdata", mem_wdata, DW'(0));
        btn_q.delete();
        sys_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("midrst_write_count", wr_cyc.size(), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
